// File: rtl/m_mem_arb_pkg.sv
// Shared encodings for the core / micro-controller memory arbiter:
// access codes, arbiter FSM states and the latched command layout.
package m_mem_arb_pkg;

  localparam logic [1:0] ACCESS_CODE  = 2'd0;
  localparam logic [1:0] ACCESS_READ  = 2'd1;
  localparam logic [1:0] ACCESS_WRITE = 2'd2;
  localparam logic [1:0] ACCESS_NONE  = 2'd3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef struct packed {
    logic [1:0]  req;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  ctrl;
  } mem_cmd_t;

  // Instruction fetches return data exactly like loads.
  function automatic logic returns_data(input logic [1:0] req);
    return (req == ACCESS_READ) || (req == ACCESS_CODE);
  endfunction

endpackage

// File: rtl/m_rr_arb2.sv
// Two-way round-robin picker: a lone request wins outright, a tie goes to
// the requester that was not granted last.
module m_rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt,
  output logic id
);

  always_comb begin
    gnt = req0 | req1;
    if (req0 && req1) begin
      id = ~last;
    end else begin
      id = req1;
    end
  end

endmodule

// File: rtl/m_mem_arb.sv
// Shares the single MMU/DRAM command port between the core (id 0) and the
// VirtIO micro-controller (id 1); one transaction in flight at a time.
module m_mem_arb
  import m_mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 10
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [1:0]  c_req,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  input  logic [2:0]  c_ctrl,
  output logic        c_stall,
  output logic [31:0] c_rdata,
  input  logic [1:0]  m_req,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  input  logic [2:0]  m_ctrl,
  output logic        m_stall,
  output logic [31:0] m_rdata,
  output logic [1:0]  mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_ctrl,
  output logic        mem_we,
  input  logic        mem_busy,
  input  logic        mem_done,
  input  logic [31:0] mem_rdata,
  output logic        err
);

  // Last WAIT cycle before a missing completion is forced.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mem_cmd_t         cmd_q, cmd_d;
  logic [31:0]      c_rdata_q, c_rdata_d;
  logic [31:0]      m_rdata_q, m_rdata_d;

  logic     c_pend, m_pend;
  logic     arb_gnt, arb_id;
  mem_cmd_t c_cmd, m_cmd;

  assign c_pend = (c_req != ACCESS_NONE);
  assign m_pend = (m_req != ACCESS_NONE);
  assign c_cmd  = '{req: c_req, addr: c_addr, wdata: c_wdata, ctrl: c_ctrl};
  assign m_cmd  = '{req: m_req, addr: m_addr, wdata: m_wdata, ctrl: m_ctrl};

  m_rr_arb2 u_pick (
    .req0 (c_pend),
    .req1 (m_pend),
    .last (last_q),
    .gnt  (arb_gnt),
    .id   (arb_id)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    c_rdata_d = c_rdata_q;
    m_rdata_d = m_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (arb_gnt) begin
          owner_d = arb_id;
          cmd_d   = arb_id ? m_cmd : c_cmd;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!mem_busy) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_done) begin
          // Write completions leave the requester's last read value alone.
          if (returns_data(cmd_q.req)) begin
            if (owner_q) begin
              m_rdata_d = mem_rdata;
            end else begin
              c_rdata_d = mem_rdata;
            end
          end
          state_d = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          err_d = 1'b1;
          if (owner_q) begin
            m_rdata_d = '0;
          end else begin
            c_rdata_d = '0;
          end
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        last_d  = owner_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      cmd_q     <= '0;
      c_rdata_q <= '0;
      m_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      c_rdata_q <= c_rdata_d;
      m_rdata_q <= m_rdata_d;
    end
  end

  // A requester is released only in the RESP cycle of its own transaction.
  assign c_stall = c_pend && !((state_q == ST_RESP) && (owner_q == 1'b0));
  assign m_stall = m_pend && !((state_q == ST_RESP) && (owner_q == 1'b1));

  assign mem_req   = (state_q == ST_ISSUE) ? cmd_q.req : ACCESS_NONE;
  assign mem_addr  = cmd_q.addr;
  assign mem_wdata = cmd_q.wdata;
  assign mem_ctrl  = cmd_q.ctrl;
  assign mem_we    = (state_q == ST_ISSUE) && (cmd_q.req == ACCESS_WRITE);

  assign c_rdata = c_rdata_q;
  assign m_rdata = m_rdata_q;
  assign err     = err_q;

endmodule
